// File: rtl/cpu_pkg.sv
// Shared CPU definitions: internal function codes used by the decoder, E1 and
// the E2 HI/LO stage.
package cpu_pkg;

  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MADD  = 6'h1C;
  localparam logic [5:0] FN_MADDU = 6'h1D;
  localparam logic [5:0] FN_MSUB  = 6'h1E;
  localparam logic [5:0] FN_MSUBU = 6'h1F;
  localparam logic [5:0] FN_CLZ   = 6'h20;
  localparam logic [5:0] FN_CLO   = 6'h21;

endpackage

// File: rtl/ex2_hilo_stage_if.sv
// Bundle between the E2/M pipeline registers and the second execute stage.
//   master: pipeline side, drives ALU flags/result, multiply value, Func, enables;
//           receives Out and the C/Z/O/N flags.
//   slave:  the ex2_hilo_stage itself.
interface ex2_hilo_stage_if #(
  parameter int unsigned DATA_W = 32
);

  logic                  ALUC;
  logic                  ALUZ;
  logic                  ALUO;
  logic                  ALUN;
  logic                  ACCEn;
  logic                  MULOp;
  logic [DATA_W-1:0]     ALUIn;
  logic [2*DATA_W-1:0]   MULIn;
  logic [5:0]            Func;
  logic [DATA_W-1:0]     Out;
  logic                  C;
  logic                  Z;
  logic                  O;
  logic                  N;

  modport master (
    output ALUC, ALUZ, ALUO, ALUN, ACCEn, MULOp, ALUIn, MULIn, Func,
    input  Out, C, Z, O, N
  );

  modport slave (
    input  ALUC, ALUZ, ALUO, ALUN, ACCEn, MULOp, ALUIn, MULIn, Func,
    output Out, C, Z, O, N
  );

endinterface

// File: rtl/hilo_acc.sv
// HI/LO accumulator pair with 64-bit load / add / subtract and MTHI/MTLO.
//   Clock, nReset : rising-edge clock, async active-low reset (clears HI/LO)
//   acc_en        : write enable for this instruction
//   func          : internal function code selecting the update
//   mul_in        : product, or source word in the low half for MTHI/MTLO
//   hi, lo        : registered HI and LO
module hilo_acc
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                acc_en,
  input  logic [5:0]          func,
  input  logic [2*DATA_W-1:0] mul_in,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_d;

  // Arithmetic is modulo 2^(2*DATA_W); carry and borrow are simply dropped.
  always_comb begin
    acc_d = acc_q;
    if (acc_en) begin
      case (func)
        FN_MULT, FN_MULTU: acc_d = mul_in;
        FN_MADD, FN_MADDU: acc_d = acc_q + mul_in;
        FN_MSUB, FN_MSUBU: acc_d = acc_q - mul_in;
        FN_MTHI:           acc_d[2*DATA_W-1:DATA_W] = mul_in[DATA_W-1:0];
        FN_MTLO:           acc_d[DATA_W-1:0] = mul_in[DATA_W-1:0];
        default:           acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign hi = acc_q[2*DATA_W-1:DATA_W];
  assign lo = acc_q[DATA_W-1:0];

endmodule

// File: rtl/ex2_hilo_stage.sv
// Second execute stage (M stage): owns HI/LO, selects the stage result and
// regenerates flags for multiply-path results.
//   Clock, nReset : rising-edge clock, async active-low reset
//   bus (slave)   : ALU result/flags, multiply value, Func, ACCEn, MULOp in;
//                   Out and C/Z/O/N out (all combinational)
module ex2_hilo_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic             Clock,
  input  logic             nReset,
  ex2_hilo_stage_if.slave  bus
);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] result;

  hilo_acc #(
    .DATA_W (DATA_W)
  ) u_hilo_acc (
    .Clock  (Clock),
    .nReset (nReset),
    .acc_en (bus.ACCEn),
    .func   (bus.Func),
    .mul_in (bus.MULIn),
    .hi     (hi),
    .lo     (lo)
  );

  // MF* reads the registered pair only: a write in this cycle is seen next cycle.
  always_comb begin
    result = bus.ALUIn;
    if (bus.MULOp) begin
      case (bus.Func)
        FN_MFHI:                 result = hi;
        FN_MFLO:                 result = lo;
        FN_MUL, FN_CLZ, FN_CLO:  result = bus.MULIn[DATA_W-1:0];
        default:                 result = bus.ALUIn;
      endcase
    end
  end

  always_comb begin
    bus.Out = result;
    bus.C   = bus.ALUC;
    bus.Z   = bus.ALUZ;
    bus.O   = bus.ALUO;
    bus.N   = bus.ALUN;
    if (bus.MULOp) begin
      bus.C = 1'b0;
      bus.O = 1'b0;
      bus.Z = (result == '0);
      bus.N = result[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_ex2_hilo_stage.sv
// Self-checking bench for ex2_hilo_stage: a reference model predicts each
// cycle's Out and flags into a scoreboard queue, compared on the falling edge.
module tb_ex2_hilo_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;

  ex2_hilo_stage_if #(.DATA_W(32)) bus ();

  ex2_hilo_stage #(
    .DATA_W (32)
  ) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        c;
    logic        z;
    logic        o;
    logic        n;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks;
  int unsigned n_pass;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one instruction just after the rising edge and predict its outputs.
  task automatic step(input string tag, input logic mulop, input logic accen,
                      input logic [5:0] func, input logic [31:0] alu_in,
                      input logic [63:0] mul_in, input logic [3:0] cfzn);
    exp_t        e;
    logic [63:0] pair;
    @(posedge clk);
    #1;
    bus.MULOp = mulop;
    bus.ACCEn = accen;
    bus.Func  = func;
    bus.ALUIn = alu_in;
    bus.MULIn = mul_in;
    {bus.ALUC, bus.ALUZ, bus.ALUO, bus.ALUN} = cfzn;

    e.tag = tag;
    if (!mulop) begin
      e.out = alu_in;
      {e.c, e.z, e.o, e.n} = cfzn;
    end else begin
      if (func == FN_MFHI)      e.out = m_hi;
      else if (func == FN_MFLO) e.out = m_lo;
      else if (func == FN_MUL || func == FN_CLZ || func == FN_CLO) e.out = mul_in[31:0];
      else                      e.out = alu_in;
      e.c = 1'b0;
      e.o = 1'b0;
      e.z = (e.out == 32'h0);
      e.n = e.out[31];
    end
    sb.push_back(e);

    // Model state after the coming edge.
    if (accen && rst_n) begin
      pair = {m_hi, m_lo};
      if (func == FN_MULT || func == FN_MULTU)      pair = mul_in;
      else if (func == FN_MADD || func == FN_MADDU) pair = pair + mul_in;
      else if (func == FN_MSUB || func == FN_MSUBU) pair = pair - mul_in;
      else if (func == FN_MTHI)                     pair[63:32] = mul_in[31:0];
      else if (func == FN_MTLO)                     pair[31:0] = mul_in[31:0];
      {m_hi, m_lo} = pair;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val({e.tag, ".out"}, bus.Out, e.out);
      check_val({e.tag, ".c"}, {31'h0, bus.C}, {31'h0, e.c});
      check_val({e.tag, ".z"}, {31'h0, bus.Z}, {31'h0, e.z});
      check_val({e.tag, ".o"}, {31'h0, bus.O}, {31'h0, e.o});
      check_val({e.tag, ".n"}, {31'h0, bus.N}, {31'h0, e.n});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] funcs [16];
    funcs = '{FN_MUL, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_MADD,
              FN_MADDU, FN_MSUB, FN_MSUBU, FN_CLZ, FN_CLO, 6'h00, 6'h21, 6'h3F};
    n_checks = 0;
    n_pass   = 0;
    m_hi     = '0;
    m_lo     = '0;
    rst_n    = 1'b0;
    bus.MULOp = 1'b0; bus.ACCEn = 1'b0; bus.Func = '0; bus.ALUIn = '0; bus.MULIn = '0;
    {bus.ALUC, bus.ALUZ, bus.ALUO, bus.ALUN} = 4'b0;

    // Reset state with all inputs zero.
    step("rst", 1'b0, 1'b0, 6'h00, 32'h0, 64'h0, 4'b0000);
    step("rst_mf", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0000);
    @(negedge clk);
    #1 rst_n = 1'b1;

    step("pass", 1'b0, 1'b0, 6'h00, 32'h1234_5678, 64'h0, 4'b1000);
    step("pass_f", 1'b0, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0111);

    // MULT then read back.
    step("mult", 1'b0, 1'b1, FN_MULT, 32'h0, 64'h0000_0001_FFFF_FFFE, 4'b0000);
    step("mfhi1", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b1010);
    step("mflo1", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);

    // MADD wraparound.
    step("mult_ff", 1'b0, 1'b1, FN_MULTU, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);
    step("madd", 1'b0, 1'b1, FN_MADD, 32'h0, 64'h2, 4'b0000);
    step("mfhi2", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0000);
    step("mflo2", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);

    // MTLO/MTHI then MSUB.
    step("mtlo", 1'b0, 1'b1, FN_MTLO, 32'h0, 64'hAAAA_AAAA_0000_0005, 4'b0000);
    step("mthi", 1'b0, 1'b1, FN_MTHI, 32'h0, 64'h5555_5555_0000_0000, 4'b0000);
    step("mflo3", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);
    step("msub", 1'b0, 1'b1, FN_MSUB, 32'h0, 64'h7, 4'b0000);
    step("mfhi3", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0000);
    step("mflo4", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);

    // Enable gating and direct multiply-path results.
    step("gate", 1'b0, 1'b0, FN_MULT, 32'h0, 64'hDEAD, 4'b0000);
    step("mfhi4", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0000);
    step("mflo5", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);
    step("badfn", 1'b0, 1'b1, 6'h00, 32'h0, 64'h1234, 4'b0000);
    step("mflo6", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);
    step("clz", 1'b1, 1'b0, FN_CLZ, 32'h0, 64'h20, 4'b1010);
    step("clo0", 1'b1, 1'b0, FN_CLO, 32'h0, 64'h0, 4'b0000);
    step("mul", 1'b1, 1'b0, FN_MUL, 32'h0, 64'h1_8000_0001, 4'b0000);
    step("mulop_dflt", 1'b1, 1'b0, 6'h00, 32'h8000_0000, 64'h5, 4'b1111);

    // Async reset between edges while an MFHI of a nonzero HI is applied.
    step("mult_nz", 1'b0, 1'b1, FN_MULT, 32'h0, 64'h0000_0042_0000_0099, 4'b0000);
    step("mfhi_nz", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1 check_val("async_hi", bus.Out, 32'h0);
    check_val("async_z", {31'h0, bus.Z}, 32'h1);
    #1 rst_n = 1'b1;
    step("mfhi_rst", 1'b1, 1'b0, FN_MFHI, 32'h0, 64'h0, 4'b0000);
    step("mflo_rst", 1'b1, 1'b0, FN_MFLO, 32'h0, 64'h0, 4'b0000);

    // Randomised instruction mix.
    for (int i = 0; i < 60; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           funcs[$urandom_range(0, 15)], $urandom,
           {$urandom, $urandom}, 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) check_val("drain", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex2_hilo_stage.md
Name: ex2_hilo_stage

Overview:
- Second execute stage of the 6-stage MIPS-style pipeline; sits in the M stage, after the E2/M pipeline registers and before the M/W registers.
- Owns the architectural HI/LO accumulator pair.
- Selects the stage result (ALU result, HI, LO, multiply low word, or count-leading result), which feeds memory addressing, W-stage writeback and forwarding.
- Regenerates condition flags for multiply-path results.

Parameters:
- DATA_W, 32, datapath word width. HI and LO are each DATA_W wide; MULIn is 2*DATA_W wide.

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous active-low reset
- ALUC  input  1  ALU carry flag from E1/E2
- ALUZ  input  1  ALU zero flag
- ALUO  input  1  ALU overflow flag
- ALUN  input  1  ALU negative flag
- ACCEn  input  1  HI/LO write enable for this instruction
- MULOp  input  1  instruction uses the multiply/HI-LO result path
- ALUIn  input  32  ALU/link/Rs result from E2
- MULIn  input  64  upstream value: sign-correct 64-bit product, CLO/CLZ count in [31:0], or Rs in [31:0] for MTHI/MTLO
- Func  input  6  internal ALU function code
- Out  output  32  stage result
- C  output  1  flag out
- Z  output  1  flag out
- O  output  1  flag out
- N  output  1  flag out

Behaviour:
- One clock; reset is asynchronous and active-low (Clock, nReset).
- Reset clears HI and LO to 0. Outputs are combinational; with reset inputs at 0, Out=0 and all flags are 0.
- HI/LO update happens on the rising edge, only when ACCEn=1 (Func selects the operation):
  - FN_MULT/FN_MULTU: {HI,LO} <= MULIn.
  - FN_MADD/FN_MADDU: {HI,LO} <= {HI,LO} + MULIn.
  - FN_MSUB/FN_MSUBU: {HI,LO} <= {HI,LO} - MULIn.
  - Add/subtract is 64-bit modulo 2^64; no overflow trap; carry/borrow discarded.
  - FN_MTHI: HI <= MULIn[31:0], LO unchanged.
  - FN_MTLO: LO <= MULIn[31:0], HI unchanged.
  - Any other Func with ACCEn=1, or ACCEn=0: HI/LO hold.
- Out selection:
  - MULOp=0: Out = ALUIn.
  - MULOp=1 and FN_MFHI: Out = HI. FN_MFLO: Out = LO.
  - MULOp=1 and FN_MUL, FN_CLZ or FN_CLO: Out = MULIn[31:0].
  - MULOp=1 and any other Func: Out = ALUIn.
- Out reads the registered HI/LO. An MF* one cycle after a MULT/MADD/MT* sees the updated value (0-cycle hazard). No same-cycle bypass: an instruction cannot write and read HI/LO at once.
- Flags:
  - MULOp=0: C,Z,O,N = ALUC,ALUZ,ALUO,ALUN.
  - MULOp=1: C=0, O=0, Z = (Out==0), N = Out[31].
- Reset asserted mid-operation clears HI/LO immediately, regardless of Clock.

Decomposition:
- Shared package cpu_pkg holds the internal function codes: FN_MUL=6'h02, FN_MFHI=6'h10, FN_MTHI=6'h11, FN_MFLO=6'h12, FN_MTLO=6'h13, FN_MULT=6'h18, FN_MULTU=6'h19, FN_MADD=6'h1C, FN_MADDU=6'h1D, FN_MSUB=6'h1E, FN_MSUBU=6'h1F, FN_CLZ=6'h20, FN_CLO=6'h21. The same codes are used by the decoder and E1.
- One natural sub-module: hilo_acc, the HI/LO registers plus the 64-bit add/subtract/load update logic. The top level holds the output and flag muxes.

Test Plan:
- Reset then pass-through: nReset=0, then 1; MULOp=0, ALUIn=32'h1234_5678, ALUC=1, ALUN=0 -> Out=32'h1234_5678, C=1, N=0.
- MULT then read: ACCEn=1, FN_MULT, MULIn=64'h0000_0001_FFFF_FFFE for one edge; next cycle MULOp=1 with FN_MFHI -> Out=32'h1, Z=0; then FN_MFLO -> Out=32'hFFFF_FFFE, N=1.
- MADD wraparound: HI/LO=64'hFFFF_FFFF_FFFF_FFFF; FN_MADD, MULIn=2, ACCEn=1 -> FN_MFHI gives 0 (Z=1), FN_MFLO gives 1.
- MSUB and MTHI/MTLO: FN_MTLO with MULIn[31:0]=5, then FN_MTHI with 0, then FN_MSUB with MULIn=7 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE.
- Enable gating: FN_MULT with ACCEn=0 and MULIn=64'hDEAD -> HI/LO unchanged. FN_CLZ with MULOp=1 and MULIn[31:0]=32 -> Out=32, C=0, O=0.
- Async reset mid-stream: nonzero HI/LO, pulse nReset low between clock edges -> MF* returns 0 immediately after release.
